// File: rtl/vce2_pkg.sv
// Shared types and constants for the vector register file element sequencer.
package vce2_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StAddr,
    StReq,
    StResp,
    StExec,
    StDone
  } vrf_seq_state_e;

  typedef enum logic [1:0] {
    PhRs1,
    PhRs2,
    PhAcc,
    PhRd
  } vrf_phase_e;

  localparam logic [3:0] MemBeWord = 4'hF;

  // Operand phase after `ph`; PhRd means every operand is in and the ALU runs next.
  function automatic vrf_phase_e next_operand_phase(vrf_phase_e ph, logic use_rs2, logic acc);
    vrf_phase_e nxt;
    nxt = PhRd;
    case (ph)
      PhRs1: begin
        if (use_rs2) begin
          nxt = PhRs2;
        end else if (acc) begin
          nxt = PhAcc;
        end
      end
      PhRs2: begin
        if (acc) begin
          nxt = PhAcc;
        end
      end
      default: nxt = PhRd;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/vce2_vrf_seq_if.sv
// AGU strobes, OBI-style memory port and lane ALU hookup of the element sequencer.
interface vce2_vrf_seq_if #(
  parameter int unsigned AddrWidth = 32
) ();

  logic                 agu_load;
  logic                 agu_get_rs1;
  logic                 agu_get_rs2;
  logic                 agu_get_rd;
  logic                 agu_get_rd_noincr;
  logic [AddrWidth-1:0] agu_addr;

  logic                 mem_req;
  logic                 mem_gnt;
  logic                 mem_we;
  logic [AddrWidth-1:0] mem_addr;
  logic [3:0]           mem_be;
  logic [31:0]          mem_wdata;
  logic                 mem_rvalid;
  logic [31:0]          mem_rdata;

  logic [31:0]          alu_a;
  logic [31:0]          alu_b;
  logic [31:0]          alu_c;
  logic                 alu_valid;
  logic [31:0]          alu_result;

  modport master (
    output agu_load, agu_get_rs1, agu_get_rs2, agu_get_rd, agu_get_rd_noincr,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output alu_a, alu_b, alu_c, alu_valid,
    input  agu_addr, mem_gnt, mem_rvalid, mem_rdata, alu_result
  );

  modport slave (
    input  agu_load, agu_get_rs1, agu_get_rs2, agu_get_rd, agu_get_rd_noincr,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  alu_a, alu_b, alu_c, alu_valid,
    output agu_addr, mem_gnt, mem_rvalid, mem_rdata, alu_result
  );

endinterface

// File: rtl/vce2_vrf_seq.sv
// Element sequencer for the memory-mapped vector register file (one memory access in flight).
// Define VCE2_VRF_ACC_EN to add the accumulate phase (old vd read into alu_c before EXEC).
module vce2_vrf_seq
  import vce2_pkg::*;
#(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned VlWidth   = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [VlWidth-1:0] vl_i,
  input  logic               use_rs2_i,
`ifdef VCE2_VRF_ACC_EN
  input  logic               acc_i,
`endif
  output logic               busy_o,
  output logic               done_o,
  vce2_vrf_seq_if.master     bus
);

  vrf_seq_state_e state_q, state_d;
  vrf_phase_e     phase_q, phase_d;

  logic [VlWidth-1:0]   cnt_q, cnt_d;
  logic [VlWidth-1:0]   vl_q, vl_d;
  logic                 use_rs2_q, use_rs2_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic                 we_q, we_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [31:0]          a_q, a_d;
  logic [31:0]          b_q, b_d;
  logic                 acc_now;

`ifdef VCE2_VRF_ACC_EN
  logic                 acc_q, acc_d;
  logic [31:0]          c_q, c_d;
  assign acc_now = acc_q;
`else
  assign acc_now = 1'b0;
`endif

  logic agu_load, get_rs1, get_rs2, get_rd, get_rd_noincr;
  logic mem_req, alu_valid, done;

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    cnt_d         = cnt_q;
    vl_d          = vl_q;
    use_rs2_d     = use_rs2_q;
    addr_d        = addr_q;
    we_d          = we_q;
    wdata_d       = wdata_q;
    a_d           = a_q;
    b_d           = b_q;
`ifdef VCE2_VRF_ACC_EN
    acc_d         = acc_q;
    c_d           = c_q;
`endif
    agu_load      = 1'b0;
    get_rs1       = 1'b0;
    get_rs2       = 1'b0;
    get_rd        = 1'b0;
    get_rd_noincr = 1'b0;
    mem_req       = 1'b0;
    alu_valid     = 1'b0;
    done          = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          vl_d      = vl_i;
          use_rs2_d = use_rs2_i;
`ifdef VCE2_VRF_ACC_EN
          acc_d     = acc_i;
`endif
          cnt_d     = '0;
          state_d   = (vl_i != '0) ? StLoad : StDone;
        end
      end
      StLoad: begin
        agu_load = 1'b1;
        phase_d  = PhRs1;
        state_d  = StAddr;
      end
      StAddr: begin
        unique case (phase_q)
          PhRs1: get_rs1 = 1'b1;
          PhRs2: get_rs2 = 1'b1;
          PhAcc: begin
`ifdef VCE2_VRF_ACC_EN
            get_rd_noincr = 1'b1;
`endif
          end
          PhRd:  get_rd = 1'b1;
        endcase
        // The request phase only ever sees this latched copy, never the live AGU bus.
        addr_d  = bus.agu_addr & ~AddrWidth'(3);
        we_d    = (phase_q == PhRd);
        state_d = StReq;
      end
      StReq: begin
        mem_req = 1'b1;
        if (bus.mem_gnt) begin
          state_d = StResp;
        end
      end
      StResp: begin
        if (bus.mem_rvalid) begin
          if (we_q) begin
            we_d  = 1'b0;
            cnt_d = cnt_q + VlWidth'(1);
            if (cnt_d == vl_q) begin
              state_d = StDone;
            end else begin
              phase_d = PhRs1;
              state_d = StAddr;
            end
          end else begin
            case (phase_q)
              PhRs1: a_d = bus.mem_rdata;
              PhRs2: b_d = bus.mem_rdata;
`ifdef VCE2_VRF_ACC_EN
              PhAcc: c_d = bus.mem_rdata;
`endif
              default: ;
            endcase
            phase_d = next_operand_phase(phase_q, use_rs2_q, acc_now);
            state_d = (phase_d == PhRd) ? StExec : StAddr;
          end
        end
      end
      StExec: begin
        alu_valid = 1'b1;
        wdata_d   = bus.alu_result;
        phase_d   = PhRd;
        state_d   = StAddr;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      phase_q   <= PhRs1;
      cnt_q     <= '0;
      vl_q      <= '0;
      use_rs2_q <= 1'b0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
`ifdef VCE2_VRF_ACC_EN
      acc_q     <= 1'b0;
      c_q       <= '0;
`endif
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      vl_q      <= vl_d;
      use_rs2_q <= use_rs2_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      a_q       <= a_d;
      b_q       <= b_d;
`ifdef VCE2_VRF_ACC_EN
      acc_q     <= acc_d;
      c_q       <= c_d;
`endif
    end
  end

  assign busy_o = (state_q != StIdle);
  assign done_o = done;

  assign bus.agu_load          = agu_load;
  assign bus.agu_get_rs1       = get_rs1;
  assign bus.agu_get_rs2       = get_rs2;
  assign bus.agu_get_rd        = get_rd;
  assign bus.agu_get_rd_noincr = get_rd_noincr;

  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_be    = MemBeWord;
  assign bus.mem_wdata = wdata_q;

  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_valid = alu_valid;
`ifdef VCE2_VRF_ACC_EN
  assign bus.alu_c     = c_q;
`else
  assign bus.alu_c     = '0;
`endif

endmodule
